bh1750_i2c_responder: RTL and testbench
=======================================

Name: bh1750_i2c_responder

Overview:
I2C target (slave) that emulates the BH1750 ambient-light sensor on the `scl`/`sda` bus. It is the other end of the existing BH1750 master driver. It accepts one-byte opcode writes and answers two-byte measurement reads from a host-supplied 16-bit value. It serves as an in-fabric sensor stand-in for loop-back bring-up and system simulation. Top level owns the `sda` inout; this block sees SDA as a separate input and open-drain enable.

Parameters:
DEV_ADDR, 7'h23, 7-bit target address (BH1750 with ADDR pin low).

Ports:
I_clk  input  1  system clock (50 MHz); I_clk must be at least 10x the SCL frequency.
sys_rst  input  1  synchronous, active-high reset.
scl  input  1  I2C clock from the bus (asynchronous).
sda_i  input  1  I2C data, as read from the bus (asynchronous).
sda_oe  output  1  1 = pull SDA low; 0 = release.
lux_data  input  16  measurement value returned on reads.
opcode  output  8  last opcode byte written by the master.
opcode_valid  output  1  one-cycle pulse when `opcode` updates.
rd_done  output  1  one-cycle pulse when the master NACKs a read byte.
busy  output  1  high while this device is addressed (address ACK through STOP, mismatching START, or reset).

Behaviour:
- Input conditioning:
  - `scl` and `sda_i` each pass through a 2-FF synchronizer plus one history FF.
  - Derived signals: scl_rise, scl_fall, start (SDA 1->0 while SCL high), stop (SDA 0->1 while SCL high).
- Reset values: sda_oe=0, opcode=8'h00, opcode_valid=0, rd_done=0, busy=0, state=IDLE, bit counter=0.
- Data timing:
  - SDA is sampled on scl_rise.
  - sda_oe changes only in the cycle after scl_fall is detected, except START/STOP/reset, which release it immediately.
- States: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE.
- Transitions:
  - Any state, on start: go to ADDR, clear bit counter, sda_oe=0, busy=0. This covers repeated START.
  - Any state, on stop: go to IDLE, sda_oe=0, busy=0.
  - IDLE: wait for start.
  - ADDR: shift 8 bits MSB first.
    - On the 8th scl_rise, if addr[7:1]==DEV_ADDR: go to ADDR_ACK and set busy=1.
    - If R/W=1, latch lux_data into a 16-bit snapshot in that same cycle.
    - On mismatch: go to IGNORE with sda_oe kept 0.
  - ADDR_ACK: drive sda_oe=1 from the following scl_fall through the 9th SCL pulse.
    - At the next scl_fall, write: release SDA, go to WR_DATA.
    - At the next scl_fall, read: drive snapshot[15] (sda_oe = ~bit), go to RD_DATA.
  - WR_DATA: shift 8 bits.
    - On the 8th scl_rise: opcode <= byte and opcode_valid=1 for one cycle; go to WR_ACK.
  - WR_ACK: ACK as in ADDR_ACK, then back to WR_DATA. Unlimited bytes; each is ACKed and pulses opcode_valid.
  - RD_DATA: shift out the current byte MSB first, changing after each scl_fall.
    - After the 8th bit's scl_fall: release SDA, go to RD_ACK.
  - RD_ACK: sample SDA on scl_rise.
    - ACK (0): at scl_fall, drive the next byte. Order is MSB byte, LSB byte, then wrap to MSB byte of the same snapshot.
    - NACK (1): pulse rd_done, go to IGNORE with SDA released.
  - IGNORE: sda_oe=0; wait for start/stop.
- Snapshot rule: lux_data changes mid-read do not affect transmitted bytes.
- Simultaneous events:
  - start/stop takes priority over scl edges in the same cycle.
  - sys_rst overrides everything.
  - Reset mid-transfer releases SDA in the next cycle.
- General call (addr 0) and 10-bit addressing are not supported; both are treated as mismatch.
- Clock stretching is never used: `scl` is input only.

Test Plan:
1. START, 0x46 (0x23+W), 0x10, STOP -> ACK at address and data 9th clocks; opcode=8'h10; single opcode_valid pulse; busy 1 from address ACK to STOP.
2. lux_data=16'hABCD; START, 0x47, master ACKs byte 1, NACKs byte 2, STOP -> bytes 0xAB then 0xCD on SDA; rd_done pulses once. Changing lux_data to 16'h1234 after address ACK still yields 0xAB/0xCD.
3. START, 0xB8 (addr 0x5C) -> sda_oe stays 0 for the whole transfer; no opcode_valid; busy stays 0.
4. Write 0x01, repeated START, 0x47, master ACKs three bytes with lux_data=16'h00FF -> opcode=8'h01; bytes 0x00, 0xFF, 0x00 (wrap).
5. STOP inserted after bit 4 of a read byte while sda_oe=1 -> sda_oe=0 within 1 cycle of stop detection; state IDLE; a following START/0x46/0x07 write succeeds with opcode=8'h07.
6. Assert sys_rst for 1 cycle during the ADDR_ACK low phase -> sda_oe=0 next cycle; all outputs at reset values; no ACK until the next START.

Source files
------------

// File: rtl/bh1750_i2c_responder_if.sv
// bh1750_i2c_responder_if: I2C bus bundle (scl, sda_i from the bus; sda_oe open-drain pull-low enable back to the pad)
interface bh1750_i2c_responder_if;
  logic scl;
  logic sda_i;
  logic sda_oe;
  modport master (output scl, sda_i, input sda_oe);
  modport slave (input scl, sda_i, output sda_oe);
endinterface

// File: rtl/bh1750_i2c_responder.sv
// bh1750_i2c_responder: BH1750 I2C target emulator; I_clk/sys_rst, bus(scl, sda_i in, sda_oe out), lux_data in, opcode/opcode_valid/rd_done/busy out
module bh1750_i2c_responder #(
  parameter logic [6:0] DEV_ADDR = 7'h23
) (
  input  logic                         I_clk,
  input  logic                         sys_rst,
  bh1750_i2c_responder_if.slave        bus,
  input  logic [15:0]                  lux_data,
  output logic [7:0]                   opcode,
  output logic                         opcode_valid,
  output logic                         rd_done,
  output logic                         busy
);
  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] ADDR     = 3'd1;
  localparam logic [2:0] ADDR_ACK = 3'd2;
  localparam logic [2:0] WR_DATA  = 3'd3;
  localparam logic [2:0] WR_ACK   = 3'd4;
  localparam logic [2:0] RD_DATA  = 3'd5;
  localparam logic [2:0] RD_ACK   = 3'd6;
  localparam logic [2:0] IGNORE   = 3'd7;
  logic [2:0] scl_s, sda_s, state, bit_cnt;
  logic [6:0] sh, tx;
  logic [15:0] snap;
  logic [7:0] nb;
  logic rd, byte_sel, oe, sda, scl_hi, scl_rise, scl_fall, start, stop;
  always_ff @(posedge I_clk) begin
    scl_s <= {scl_s[1:0], bus.scl};
    sda_s <= {sda_s[1:0], bus.sda_i};
  end
  assign sda = sda_s[1];
  assign scl_hi = scl_s[1] & scl_s[2];
  assign scl_rise = scl_s[1] & ~scl_s[2];
  assign scl_fall = ~scl_s[1] & scl_s[2];
  assign start = scl_hi & sda_s[2] & ~sda_s[1];
  assign stop = scl_hi & ~sda_s[2] & sda_s[1];
  assign nb = byte_sel ? snap[15:8] : snap[7:0];
  assign bus.sda_oe = oe;
  always_ff @(posedge I_clk) begin
    opcode_valid <= 1'b0;
    rd_done <= 1'b0;
    if (sys_rst) begin
      state <= IDLE;
      bit_cnt <= '0;
      oe <= 1'b0;
      opcode <= '0;
      busy <= 1'b0;
    end else if (start) begin
      state <= ADDR;
      bit_cnt <= '0;
      oe <= 1'b0;
      busy <= 1'b0;
    end else if (stop) begin
      state <= IDLE;
      oe <= 1'b0;
      busy <= 1'b0;
    end else begin
      case (state)
        ADDR, WR_DATA: if (scl_rise) begin
          sh <= {sh[5:0], sda};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            if (state == WR_DATA) begin
              opcode <= {sh, sda};
              opcode_valid <= 1'b1;
              state <= WR_ACK;
            end else if (sh == DEV_ADDR) begin
              state <= ADDR_ACK;
              busy <= 1'b1;
              rd <= sda;
              if (sda) snap <= lux_data;
            end else begin
              state <= IGNORE;
            end
          end
        end
        // oe low on entry marks the first fall (start ACK); oe high marks the fall ending the ACK pulse
        ADDR_ACK, WR_ACK: if (scl_fall) begin
          if (!oe) begin
            oe <= 1'b1;
          end else if (state == ADDR_ACK && rd) begin
            oe <= ~snap[15];
            tx <= snap[14:8];
            byte_sel <= 1'b0;
            state <= RD_DATA;
          end else begin
            oe <= 1'b0;
            state <= WR_DATA;
          end
        end
        RD_DATA: if (scl_fall) begin
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            oe <= 1'b0;
            state <= RD_ACK;
          end else begin
            oe <= ~tx[6];
            tx <= {tx[5:0], 1'b0};
          end
        end
        RD_ACK: if (scl_rise && sda) begin
          rd_done <= 1'b1;
          state <= IGNORE;
        end else if (scl_fall) begin
          oe <= ~nb[7];
          tx <= nb[6:0];
          byte_sel <= ~byte_sel;
          state <= RD_DATA;
        end
        default: oe <= 1'b0;
      endcase
    end
  end
endmodule

// File: tb/tb_bh1750_i2c_responder.sv
// tb_bh1750_i2c_responder: bit-banged I2C master driving the responder, with a queue scoreboard checked by a separate monitor
module tb_bh1750_i2c_responder;
  localparam logic [1:0] K_ACK = 2'd0, K_BYTE = 2'd1, K_OPC = 2'd2, K_RDD = 2'd3;
  logic clk = 1'b0, rst = 1'b1, scl_m = 1'b1, m_sda = 1'b1, ovr = 1'b0;
  logic [15:0] lux = '0;
  logic [7:0] opcode;
  logic opcode_valid, rd_done, busy, r;
  int n_chk = 0, n_fail = 0, oe_cnt = 0, busy_cnt = 0, oe0, busy0;
  logic [9:0] exp_q[$], obs_q[$];
  bh1750_i2c_responder_if bus();
  assign bus.scl = scl_m;
  assign bus.sda_i = ovr ? m_sda : (m_sda & ~bus.sda_oe);
  bh1750_i2c_responder #(.DEV_ADDR(7'h23)) dut (
    .I_clk(clk), .sys_rst(rst), .bus(bus), .lux_data(lux),
    .opcode(opcode), .opcode_valid(opcode_valid), .rd_done(rd_done), .busy(busy)
  );
  always #10 clk = ~clk;
  function automatic void chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction
  function automatic void sb(input logic [9:0] act, input string nm);
    logic [9:0] e;
    n_chk++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: got event %h, none expected", nm, act);
    end else begin
      e = exp_q.pop_front();
      if (e !== act) begin
        n_fail++;
        $display("FAIL %s: got kind/value %h expected %h", nm, act, e);
      end
    end
  endfunction
  always @(negedge clk) begin
    if (opcode_valid) sb({K_OPC, opcode}, "opcode_valid");
    if (rd_done) sb({K_RDD, 8'h00}, "rd_done");
    if (obs_q.size() != 0) sb(obs_q.pop_front(), "bus");
    if (bus.sda_oe) oe_cnt++;
    if (busy) busy_cnt++;
  end
  task automatic wq();
    repeat (10) @(posedge clk);
    #2;
  endtask
  task automatic expect_ev(input logic [1:0] k, input logic [7:0] v);
    exp_q.push_back({k, v});
  endtask
  task automatic bit_io(input logic b, output logic rb);
    m_sda = b; wq();
    scl_m = 1'b1; wq();
    rb = bus.sda_i; wq();
    scl_m = 1'b0; wq();
  endtask
  task automatic i2c_start();
    m_sda = 1'b1; wq();
    scl_m = 1'b1; wq();
    m_sda = 1'b0; wq();
    scl_m = 1'b0; wq();
  endtask
  task automatic i2c_stop();
    m_sda = 1'b0; wq();
    scl_m = 1'b1; wq();
    m_sda = 1'b1; wq();
  endtask
  task automatic write_byte(input logic [7:0] b);
    logic a;
    for (int i = 7; i >= 0; i--) bit_io(b[i], a);
    bit_io(1'b1, a);
    obs_q.push_back({K_ACK, 7'b0, a});
  endtask
  task automatic read_byte(input logic ack_bit);
    logic [7:0] v;
    logic a;
    for (int i = 0; i < 8; i++) begin
      bit_io(1'b1, a);
      v = {v[6:0], a};
    end
    obs_q.push_back({K_BYTE, v});
    bit_io(ack_bit, a);
  endtask
  initial begin
    logic [7:0] ab;
    repeat (5) @(posedge clk);
    #1;
    chk("reset sda_oe", 16'(bus.sda_oe), 16'h0);
    chk("reset opcode", 16'(opcode), 16'h0);
    chk("reset opcode_valid", 16'(opcode_valid), 16'h0);
    chk("reset rd_done", 16'(rd_done), 16'h0);
    chk("reset busy", 16'(busy), 16'h0);
    rst = 1'b0;
    wq();
    expect_ev(K_ACK, 8'h00); expect_ev(K_OPC, 8'h10); expect_ev(K_ACK, 8'h00);
    i2c_start(); write_byte(8'h46);
    chk("t1 busy after addr ack", 16'(busy), 16'h1);
    write_byte(8'h10);
    chk("t1 opcode", 16'(opcode), 16'h10);
    chk("t1 busy before stop", 16'(busy), 16'h1);
    i2c_stop(); wq();
    chk("t1 busy after stop", 16'(busy), 16'h0);
    lux = 16'hABCD;
    expect_ev(K_ACK, 8'h00); expect_ev(K_BYTE, 8'hAB); expect_ev(K_BYTE, 8'hCD); expect_ev(K_RDD, 8'h00);
    i2c_start(); write_byte(8'h47);
    lux = 16'h1234;
    read_byte(1'b0); read_byte(1'b1);
    i2c_stop(); wq();
    oe0 = oe_cnt; busy0 = busy_cnt;
    expect_ev(K_ACK, 8'h01); expect_ev(K_ACK, 8'h01);
    i2c_start(); write_byte(8'hB8); write_byte(8'h10);
    i2c_stop(); wq();
    chk("t3 sda_oe never asserted", 16'(oe_cnt - oe0), 16'h0);
    chk("t3 busy never asserted", 16'(busy_cnt - busy0), 16'h0);
    lux = 16'h00FF;
    expect_ev(K_ACK, 8'h00); expect_ev(K_OPC, 8'h01); expect_ev(K_ACK, 8'h00); expect_ev(K_ACK, 8'h00);
    expect_ev(K_BYTE, 8'h00); expect_ev(K_BYTE, 8'hFF); expect_ev(K_BYTE, 8'h00); expect_ev(K_BYTE, 8'hFF);
    expect_ev(K_RDD, 8'h00);
    i2c_start(); write_byte(8'h46); write_byte(8'h01);
    i2c_start(); write_byte(8'h47);
    read_byte(1'b0); read_byte(1'b0); read_byte(1'b0); read_byte(1'b1);
    i2c_stop(); wq();
    chk("t4 opcode", 16'(opcode), 16'h01);
    lux = 16'h0000;
    expect_ev(K_ACK, 8'h00);
    i2c_start(); write_byte(8'h47);
    for (int i = 0; i < 4; i++) bit_io(1'b1, r);
    chk("t5 sda_oe driving bit 5", 16'(bus.sda_oe), 16'h1);
    m_sda = 1'b0; ovr = 1'b1; wq();
    scl_m = 1'b1; wq();
    m_sda = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("t5 sda_oe released on stop", 16'(bus.sda_oe), 16'h0);
    chk("t5 busy after stop", 16'(busy), 16'h0);
    wq(); ovr = 1'b0; wq();
    expect_ev(K_ACK, 8'h00); expect_ev(K_OPC, 8'h07); expect_ev(K_ACK, 8'h00);
    i2c_start(); write_byte(8'h46); write_byte(8'h07);
    i2c_stop(); wq();
    chk("t5 opcode", 16'(opcode), 16'h07);
    ab = 8'h46;
    i2c_start();
    for (int i = 7; i >= 0; i--) bit_io(ab[i], r);
    chk("t6 ack driven before reset", 16'(bus.sda_oe), 16'h1);
    @(posedge clk); #2; rst = 1'b1;
    @(posedge clk); #1;
    chk("t6 sda_oe after reset", 16'(bus.sda_oe), 16'h0);
    chk("t6 busy after reset", 16'(busy), 16'h0);
    chk("t6 opcode after reset", 16'(opcode), 16'h0);
    chk("t6 opcode_valid after reset", 16'(opcode_valid), 16'h0);
    chk("t6 rd_done after reset", 16'(rd_done), 16'h0);
    rst = 1'b0;
    bit_io(1'b1, r);
    chk("t6 no ack after reset", 16'(r), 16'h1);
    i2c_stop(); wq();
    expect_ev(K_ACK, 8'h00);
    i2c_start(); write_byte(8'h46);
    chk("t6 busy on new address", 16'(busy), 16'h1);
    i2c_stop(); wq();
    chk("scoreboard drained", 16'(exp_q.size()), 16'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
